// File: rtl/sap_out_display.sv
// Buffers bytes from the SAP CPU OUT port in a small FIFO and shows each one on a
// single 7-segment digit: high nibble, low nibble with the decimal point, then a blank gap.
module sap_out_display #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out_valid,
    input  logic [7:0] out_data,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t           state, state_n;
    logic [7:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       disp, disp_n;
    logic [6:0]       seg_n;
    logic             dp_n;
    logic             push, pop, empty;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    // full is taken from the registered count, so a write while full is lost even if a pop happens on that edge
    assign push  = out_valid && !full;
    assign busy  = !empty || (state != IDLE);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        disp_n  = disp;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    disp_n  = mem[rd_ptr];
                    cnt_n   = CNT_W'(HOLD_CYCLES - 1);
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    cnt_n   = CNT_W'(HOLD_CYCLES - 1);
                    state_n = LOW;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    cnt_n   = CNT_W'(GAP_CYCLES - 1);
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    disp_n  = mem[rd_ptr];
                    cnt_n   = CNT_W'(HOLD_CYCLES - 1);
                    state_n = HIGH;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Segment outputs are computed from the next state so they register alongside it
        seg_n = '0;
        dp_n  = 1'b0;
        case (state_n)
            HIGH:    seg_n = hex7(disp_n[7:4]);
            LOW: begin
                seg_n = hex7(disp_n[3:0]);
                dp_n  = 1'b1;
            end
            default: seg_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= out_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            disp     <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            seg      <= '0;
            dp       <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            disp  <= disp_n;
            seg   <= seg_n;
            dp    <= dp_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (out_valid && full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sap_out_display.sv
// Directed bench for sap_out_display: bytes are queued as they are written and
// checked nibble by nibble, cycle by cycle, as the display plays them out.
module tb_sap_out_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       out_valid;
    logic [7:0] out_data;
    logic       full, overflow, busy, dp;
    logic [6:0] seg;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    sap_out_display #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2),
        .DEPTH      (4),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_valid(out_valid),
        .out_data (out_data),
        .full     (full),
        .overflow (overflow),
        .busy     (busy),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; drives one strobe that the next rising edge samples.
    task automatic strobe(input logic [7:0] b);
        out_valid = 1'b1;
        out_data  = b;
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    // Pops the next expected byte and checks its 10-cycle display sequence from
    // phase 'skip' onward; waits at most max_wait blank cycles for it to start.
    task automatic show_byte(input int max_wait, input int skip, input bit check_lat, input int lat);
        logic [7:0] b;
        int waited;
        waited = 0;
        b = exp_q.pop_front();
        if (skip == 0)
            while (seg == 7'h00 && waited < max_wait) begin
                @(negedge clk);
                waited++;
            end
        if (check_lat) chk("latency", waited, lat);
        for (int p = skip; p < 10; p++) begin
            if (p < 4) begin
                chk($sformatf("hi_seg_%02h", b), seg, seg_of(b[7:4]));
                chk($sformatf("hi_dp_%02h", b), dp, 1'b0);
            end else if (p < 8) begin
                chk($sformatf("lo_seg_%02h", b), seg, seg_of(b[3:0]));
                chk($sformatf("lo_dp_%02h", b), dp, 1'b1);
            end else begin
                chk($sformatf("gap_seg_%02h", b), seg, 7'h00);
                chk($sformatf("gap_dp_%02h", b), dp, 1'b0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset held two cycles with a strobe present: nothing may be pushed
        rst = 1'b1;
        out_valid = 1'b1;
        out_data = 8'h55;
        @(negedge clk);
        @(negedge clk);
        chk("rst_seg", seg, 7'h00);
        chk("rst_dp", dp, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        out_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_seg", seg, 7'h00);

        // Single byte: high nibble visible one edge after the push
        exp_q.push_back(8'h3A);
        strobe(8'h3A);
        chk("single_busy", busy, 1'b1);
        show_byte(1, 0, 1'b1, 1);
        chk("single_idle_busy", busy, 1'b0);
        chk("single_idle_seg", seg, 7'h00);

        // Two bytes back to back: second starts right after the first gap
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h9F);
        strobe(8'h12);
        strobe(8'h9F);
        show_byte(1, 0, 1'b0, 0);
        show_byte(0, 0, 1'b0, 0);
        chk("pair_idle_busy", busy, 1'b0);

        // Six strobes into a 4-deep FIFO: 6th is dropped
        for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
        for (int k = 1; k <= 6; k++) begin
            out_valid = 1'b1;
            out_data = 8'(k);
            @(negedge clk);
            chk($sformatf("burst_full_%0d", k), full, (k >= 5) ? 1 : 0);
            chk($sformatf("burst_ovf_%0d", k), overflow, (k == 6) ? 1 : 0);
            if (k >= 2 && k <= 5) chk($sformatf("burst_seg_%0d", k), seg, 7'h3F);
            if (k == 6) begin
                chk("burst_seg_6", seg, 7'h06);
                chk("burst_dp_6", dp, 1'b1);
            end
        end
        out_valid = 1'b0;
        @(negedge clk);
        show_byte(0, 5, 1'b0, 0);
        for (int k = 2; k <= 5; k++) show_byte(0, 0, 1'b0, 0);
        chk("burst_idle_busy", busy, 1'b0);
        chk("burst_idle_seg", seg, 7'h00);
        chk("burst_ovf_sticky", overflow, 1'b1);

        // Reset during LOW of 0xAB with two bytes still queued
        strobe(8'hAB);
        strobe(8'h01);
        strobe(8'h02);
        repeat (3) @(negedge clk);
        chk("mid_low_seg", seg, 7'h7C);
        chk("mid_low_dp", dp, 1'b1);
        chk("mid_ovf_before_rst", overflow, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_seg", seg, 7'h00);
        chk("mid_rst_dp", dp, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_full", full, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        exp_q.push_back(8'h0C);
        strobe(8'h0C);
        show_byte(1, 0, 1'b1, 1);
        repeat (3) @(negedge clk);
        chk("mid_after_busy", busy, 1'b0);
        chk("mid_after_seg", seg, 7'h00);

        // Nibble sweep covering every hex code in order
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'h01 + 8'(i) * 8'h22;
            exp_q.push_back(b);
            strobe(b);
            show_byte(1, 0, 1'b1, 1);
        end
        chk("sweep_idle_busy", busy, 1'b0);
        chk("sweep_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sap_out_display.md
Name: sap_out_display

Overview:
- Downstream consumer of the SAP CPU top's OUT port. Captures each byte the CPU emits with an OUT instruction and buffers it in a small FIFO.
- Shows each byte on a single 7-segment digit: high nibble, then low nibble with the decimal point lit, then a blank gap.
- seg/dp map directly onto the 8-bit io_out of the tile, so fast CPU output bursts stay readable on the TT02 board display.

Parameters:
- HOLD_CYCLES, 4, cycles each nibble is shown (>=1)
- GAP_CYCLES, 2, blank cycles after each byte (>=1)
- DEPTH, 4, FIFO entries (power of two, >=2)
- CNT_W, 8, width of the hold/gap down-counter (must hold max(HOLD_CYCLES,GAP_CYCLES)-1)

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- out_valid  in  1  one-cycle strobe from the CPU OUT instruction.
- out_data  in  8  byte to display; sampled when out_valid=1.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; a write was dropped.
- busy  out  1  FIFO non-empty or state!=IDLE.
- seg  out  7  active-high segments; seg[0]=a ... seg[6]=g.
- dp  out  1  decimal point; marks the low nibble.

Behaviour:
- Reset: one clock, synchronous, active-high; takes effect at the next rising edge.
  - FIFO empty; state IDLE; counter 0.
  - seg=0, dp=0, full=0, overflow=0, busy=0.
  - rst mid-display aborts at that edge; FIFO contents are discarded.
- All outputs are registered. full is derived from the registered count.
- FIFO push on an edge with out_valid=1 and full=0.
- out_valid=1 while full=1:
  - Byte dropped; overflow<=1.
  - The byte is dropped even if a pop occurs on the same edge.
  - overflow clears only on rst.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, HIGH, LOW, GAP.
  - IDLE: seg=0, dp=0. If FIFO non-empty: pop into the display register, counter<=HOLD_CYCLES-1, go HIGH.
  - HIGH: seg=hex(d[7:4]), dp=0. counter decrements each cycle; at 0: counter<=HOLD_CYCLES-1, go LOW.
  - LOW: seg=hex(d[3:0]), dp=1. At 0: counter<=GAP_CYCLES-1, go GAP.
  - GAP: seg=0, dp=0. At 0: if FIFO non-empty, pop, reload HOLD_CYCLES-1 and go HIGH (no IDLE cycle); else go IDLE.
- seg/dp are registered with the state, so they reflect the new state after the transition edge.
- Latency: a byte pushed on edge N into an empty FIFO while IDLE is popped on edge N+1. Its high nibble is visible from after edge N+1.
- Per byte: exactly HOLD_CYCLES high + HOLD_CYCLES low + GAP_CYCLES blank cycles.
- Hex encoding seg[6:0]:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71

Test Plan:
- Reset: hold rst 2 cycles with out_valid=1 -> seg=0, dp=0, full=0, overflow=0, busy=0. Nothing is pushed.
- Single byte 0x3A, default parameters (HOLD_CYCLES=4, GAP_CYCLES=2, DEPTH=4), strobe on edge N:
  - seg=4F, dp=0 for 4 cycles after edge N+1.
  - Then seg=77, dp=1 for 4 cycles.
  - Then seg=00 for 2 cycles, then IDLE with busy=0.
- Bytes 0x12 then 0x9F, both queued before the first finishes:
  - Sequence 06, 5B(dp), blank x2, then immediately 6F, 71(dp), blank x2.
  - No extra IDLE cycle between the two bytes.
- Six consecutive strobes 0x01..0x06, DEPTH=4:
  - The pop on the 2nd edge keeps count at 1; full=1 after the 5th write.
  - 6th byte dropped; overflow=1.
  - Display shows 01..05 only; overflow stays 1 until rst.
- Reset mid-display: assert rst during LOW of 0xAB with 2 bytes queued -> next cycle seg=0, busy=0, FIFO empty. A new write 0x0C then displays 3F, then 39 with dp=1.
- Nibble sweep: write 0x01, 0x23, ..., 0xEF -> every hex code in the table appears once, in order.
